multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the LEGv8 core: replaces per-instruction combinational decode with a state machine that walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK over several clocks. It sits beside the shared datapath (one ALU, one unified instruction/data memory port, register file, IR, branch-target register) and drives its enables and muxes each cycle. Memory accesses use a ready handshake, so the block stalls on variable-latency memory.

## Interface
Parameters:
- none

Ports:
- CLK  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- opcode  input  11  IR[31:21]; valid from DECODE onward
- zero  input  1  ALU zero flag, valid in CBZ_EXEC
- mem_ready  input  1  memory completed the current request this cycle
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  request is a write (STUR)
- iord  output  1  memory address: 0 = PC, 1 = ALU-out register
- ir_we  output  1  load IR from memory read data
- pc_we  output  1  update PC
- pc_sel  output  1  PC source: 0 = PC+4, 1 = branch-target register
- tgt_we  output  1  latch PC + (signext<<2) into branch-target register
- rf_we  output  1  register-file write
- mem2reg  output  1  write-back source: 0 = ALU-out, 1 = memory-data register
- reg2loc  output  1  read port B: 0 = Rm, 1 = Rt
- alusrc  output  1  ALU B: 0 = register, 1 = extended immediate
- aluop  output  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
- signop  output  3  000 I, 001 D, 010 B, 011 CB, 100 MOVZ
- halted  output  1  illegal opcode decoded; sticky
- state  output  4  current state encoding (debug)

## Operation
- Decode classes (casez, priority top-down): LDUR ??111000010, STUR ??111000000, ADDREG ?0?01011???, SUBREG ?1?01011???, ANDREG ?0001010???, ORRREG ?0101010???, ADDIMM ?0?10001???, SUBIMM ?1?10001???, CBZ ?011010????, B ?00101?????, MOVZ 110100101??; anything else illegal.
- States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, EXEC_MOVZ 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, CBZ_EXEC 10, JUMP 11, HALT 15.
- FETCH: mem_req=1, iord=0, mem_we=0; on mem_ready: ir_we=1, pc_we=1, pc_sel=0, next DECODE; else stay.
- DECODE: tgt_we=1, reg2loc=1 for STUR/CBZ else 0, signop by class (B 010, CB 011 for CBZ, else 000). Next: R-type→EXEC_R, I-type→EXEC_I, MOVZ→EXEC_MOVZ, LDUR/STUR→ADDR, CBZ→CBZ_EXEC, B→JUMP, illegal→HALT.
- EXEC_R: alusrc=0, aluop per op → WB_ALU. EXEC_I: alusrc=1, signop=000, aluop ADD/SUB → WB_ALU. EXEC_MOVZ: alusrc=1, signop=100, aluop=0111 → WB_ALU.
- ADDR: alusrc=1, signop=001, aluop=0010 → MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_req=1, iord=1; on mem_ready → WB_MEM. MEM_WR: mem_req=1, mem_we=1, iord=1, reg2loc=1; on mem_ready → FETCH.
- WB_ALU: rf_we=1, mem2reg=0 → FETCH. WB_MEM: rf_we=1, mem2reg=1 → FETCH.
- CBZ_EXEC: reg2loc=1, alusrc=0, aluop=0111; pc_we=zero, pc_sel=1 → FETCH.
- JUMP: pc_we=1, pc_sel=1 → FETCH.
- HALT: halted=1, all enables 0; remains until reset.
- Outputs not listed for a state are 0. opcode is sampled only in DECODE; class held in a registered field for later states.

## Timing
- Reset: next state FETCH, halted=0; while reset high all of mem_req, mem_we, ir_we, pc_we, tgt_we, rf_we forced 0; state reads 0 after the reset edge.
- Handshake: mem_req, mem_we, iord stable from assertion until the cycle mem_ready=1 (inclusive); mem_ready ignored when mem_req=0. mem_ready in same cycle as first mem_req legal (zero wait).
- Cycles with zero-wait memory: R/I/MOVZ 4, LDUR 5, STUR 4, CBZ 3, B 3. Each wait cycle adds one in FETCH/MEM_RD/MEM_WR.
- pc_we/ir_we in FETCH and pc_we in CBZ_EXEC are Mealy (same-cycle on mem_ready/zero); all others Moore.
- Reset mid-memory-wait: request dropped at the edge; controller restarts in FETCH.

## Test plan
- Reset then ADDREG (opcode 10001011000), mem_ready always 1 -> states 0,1,2,8,0; rf_we=1 only in state 8, aluop=0010.
- LDUR (11111000010), mem_ready low 2 cycles in MEM_RD -> mem_req/iord held 3 cycles, then WB_MEM rf_we=1 mem2reg=1; total 7 cycles.
- CBZ (10110100xxx) with zero=1 -> pc_we=1 pc_sel=1 in state 10; with zero=0 -> pc_we=0; both 3 cycles.
- STUR then B (00010100000) -> mem_we=1 only in MEM_WR; JUMP pc_we=1 pc_sel=1.
- Illegal opcode 00000000000 -> HALT, halted=1 sticky for 10 cycles, all enables 0; reset -> halted=0, FETCH.
- Reset asserted mid-FETCH wait -> next cycle mem_req=0 while reset held; release -> FETCH restarts.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencing controller for a LEGv8 core. It walks each
//   instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK on a
//   shared datapath and drives the datapath enables and mux selects each
//   cycle. Memory accesses use a ready handshake, so the controller stalls
//   in FETCH / MEM_RD / MEM_WR until mem_ready is seen.
//
// Ports
//   CLK        in   rising-edge clock
//   reset      in   synchronous, active-high
//   opcode     in   [10:0] IR[31:21], sampled only in DECODE
//   zero       in   ALU zero flag (used in CBZ_EXEC)
//   mem_ready  in   memory completed the current request this cycle
//   mem_req    out  memory request, held until mem_ready
//   mem_we     out  request is a write
//   iord       out  memory address select: 0 = PC, 1 = ALU-out register
//   ir_we      out  load IR from memory read data
//   pc_we      out  update PC
//   pc_sel     out  PC source: 0 = PC+4, 1 = branch-target register
//   tgt_we     out  latch branch target
//   rf_we      out  register-file write
//   mem2reg    out  write-back source: 0 = ALU-out, 1 = memory data
//   reg2loc    out  read port B: 0 = Rm, 1 = Rt
//   alusrc     out  ALU B: 0 = register, 1 = extended immediate
//   aluop      out  [3:0] ALU operation
//   signop     out  [2:0] immediate-extension format
//   halted     out  illegal opcode decoded; sticky until reset
//   state      out  [3:0] current state encoding (debug)

module multicycle_control (
    input  logic        CLK,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        tgt_we,
    output logic        rf_we,
    output logic        mem2reg,
    output logic        reg2loc,
    output logic        alusrc,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic        halted,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_EXEC_MOVZ = 4'd4,
        S_ADDR      = 4'd5,
        S_MEM_RD    = 4'd6,
        S_MEM_WR    = 4'd7,
        S_WB_ALU    = 4'd8,
        S_WB_MEM    = 4'd9,
        S_CBZ_EXEC  = 4'd10,
        S_JUMP      = 4'd11,
        S_HALT      = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        C_LDUR, C_STUR, C_ADDREG, C_SUBREG, C_ANDREG, C_ORRREG,
        C_ADDIMM, C_SUBIMM, C_CBZ, C_B, C_MOVZ, C_ILLEGAL
    } cls_t;

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    cls_t   dec_cls;

    // Priority decode of the live opcode; first matching pattern wins.
    always_comb begin
        dec_cls = C_ILLEGAL;
        casez (opcode)
            11'b??111000010: dec_cls = C_LDUR;
            11'b??111000000: dec_cls = C_STUR;
            11'b?0?01011???: dec_cls = C_ADDREG;
            11'b?1?01011???: dec_cls = C_SUBREG;
            11'b?0001010???: dec_cls = C_ANDREG;
            11'b?0101010???: dec_cls = C_ORRREG;
            11'b?0?10001???: dec_cls = C_ADDIMM;
            11'b?1?10001???: dec_cls = C_SUBIMM;
            11'b?011010????: dec_cls = C_CBZ;
            11'b?00101?????: dec_cls = C_B;
            11'b110100101??: dec_cls = C_MOVZ;
            default:         dec_cls = C_ILLEGAL;
        endcase
    end

    // The class is captured once in DECODE; later states use the registered
    // copy because the IR input is not guaranteed stable afterwards.
    assign cls_d = (state_q == S_DECODE) ? dec_cls : cls_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_ILLEGAL;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        iord    = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        tgt_we  = 1'b0;
        rf_we   = 1'b0;
        mem2reg = 1'b0;
        reg2loc = 1'b0;
        alusrc  = 1'b0;
        aluop   = 4'b0000;
        signop  = 3'b000;
        halted  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                tgt_we  = 1'b1;
                reg2loc = (dec_cls == C_STUR) || (dec_cls == C_CBZ);
                if (dec_cls == C_B)        signop = 3'b010;
                else if (dec_cls == C_CBZ) signop = 3'b011;
                case (dec_cls)
                    C_ADDREG, C_SUBREG, C_ANDREG, C_ORRREG: state_d = S_EXEC_R;
                    C_ADDIMM, C_SUBIMM:                     state_d = S_EXEC_I;
                    C_MOVZ:                                 state_d = S_EXEC_MOVZ;
                    C_LDUR, C_STUR:                         state_d = S_ADDR;
                    C_CBZ:                                  state_d = S_CBZ_EXEC;
                    C_B:                                    state_d = S_JUMP;
                    default:                                state_d = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                case (cls_q)
                    C_SUBREG: aluop = 4'b0110;
                    C_ANDREG: aluop = 4'b0000;
                    C_ORRREG: aluop = 4'b0001;
                    default:  aluop = 4'b0010;
                endcase
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                alusrc  = 1'b1;
                aluop   = (cls_q == C_SUBIMM) ? 4'b0110 : 4'b0010;
                state_d = S_WB_ALU;
            end
            S_EXEC_MOVZ: begin
                alusrc  = 1'b1;
                signop  = 3'b100;
                aluop   = 4'b0111;
                state_d = S_WB_ALU;
            end
            S_ADDR: begin
                alusrc  = 1'b1;
                signop  = 3'b001;
                aluop   = 4'b0010;
                state_d = (cls_q == C_STUR) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                reg2loc = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_WB_ALU: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_MEM: begin
                rf_we   = 1'b1;
                mem2reg = 1'b1;
                state_d = S_FETCH;
            end
            S_CBZ_EXEC: begin
                reg2loc = 1'b1;
                aluop   = 4'b0111;
                pc_we   = zero;
                pc_sel  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_sel  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase

        // Side-effecting strobes are suppressed for the whole reset cycle,
        // including a FETCH that was mid-wait when reset arrived.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            tgt_we  = 1'b0;
            rf_we   = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_we, pc_we, pc_sel, tgt_we, rf_we;
    logic        mem2reg, reg2loc, alusrc, halted;
    logic [3:0]  aluop, state;
    logic [2:0]  signop;

    multicycle_control dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .tgt_we(tgt_we), .rf_we(rf_we), .mem2reg(mem2reg),
        .reg2loc(reg2loc), .alusrc(alusrc), .aluop(aluop),
        .signop(signop), .halted(halted), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef enum int {
        K_LDUR, K_STUR, K_ADDREG, K_SUBREG, K_ANDREG, K_ORRREG,
        K_ADDIMM, K_SUBIMM, K_CBZ, K_B, K_MOVZ, K_ILL
    } kind_t;

    // One expected clock of an instruction. fetch/cbz mark the same-cycle
    // strobes; waits means the step repeats until mem_ready; sticky never ends.
    typedef struct packed {
        logic [3:0]  st;
        logic        mreq, mwe, iord, pcsel, tgt, rfwe, m2r, r2l, asrc, pcwe;
        logic [3:0]  aop;
        logic [2:0]  sop;
        logic        halt, fetch, cbz, waits, sticky, dec;
        logic [10:0] op;
    } step_t;

    step_t       plan[$];
    logic [22:0] trace[$];
    int          checks = 0;
    int          errors = 0;
    int          stall_st = -1;
    int          stall_left = 0;
    int          zero_force = -1;
    bit          rand_ready = 0;
    int          consec_wait = 0;
    int          cyc_count = 0;

    function automatic kind_t classify(input logic [10:0] op);
        casez (op)
            11'b??111000010: return K_LDUR;
            11'b??111000000: return K_STUR;
            11'b?0?01011???: return K_ADDREG;
            11'b?1?01011???: return K_SUBREG;
            11'b?0001010???: return K_ANDREG;
            11'b?0101010???: return K_ORRREG;
            11'b?0?10001???: return K_ADDIMM;
            11'b?1?10001???: return K_SUBIMM;
            11'b?011010????: return K_CBZ;
            11'b?00101?????: return K_B;
            11'b110100101??: return K_MOVZ;
            default:         return K_ILL;
        endcase
    endfunction

    function automatic logic [10:0] gen_op(input bit want_legal);
        logic [10:0] o;
        for (int i = 0; i < 2000; i++) begin
            o = 11'($urandom);
            if ((classify(o) != K_ILL) == want_legal) return o;
        end
        return want_legal ? 11'b10001011000 : 11'b00000000000;
    endfunction

    function automatic logic [22:0] act_vec();
        return {state, mem_req, mem_we, iord, ir_we, pc_we, pc_sel, tgt_we,
                rf_we, mem2reg, reg2loc, alusrc, aluop, signop, halted};
    endfunction

    function automatic logic [22:0] exp_vec(input step_t s, input bit rdy, input bit z);
        return {s.st, s.mreq, s.mwe, s.iord, s.fetch & rdy,
                s.pcwe | (s.fetch & rdy) | (s.cbz & z), s.pcsel, s.tgt,
                s.rfwe, s.m2r, s.r2l, s.asrc, s.aop, s.sop, s.halt};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Expand an instruction into its per-clock expectations.
    task automatic add_instr(input logic [10:0] op);
        kind_t k;
        step_t s;
        k = classify(op);
        s = '0; s.mreq = 1; s.fetch = 1; s.waits = 1;
        plan.push_back(s);
        s = '0; s.st = 4'd1; s.tgt = 1; s.dec = 1; s.op = op;
        s.r2l = (k == K_STUR) || (k == K_CBZ);
        s.sop = (k == K_B) ? 3'b010 : (k == K_CBZ) ? 3'b011 : 3'b000;
        plan.push_back(s);
        case (k)
            K_ADDREG, K_SUBREG, K_ANDREG, K_ORRREG: begin
                s = '0; s.st = 4'd2;
                s.aop = (k == K_ADDREG) ? 4'b0010 : (k == K_SUBREG) ? 4'b0110 :
                        (k == K_ANDREG) ? 4'b0000 : 4'b0001;
                plan.push_back(s);
            end
            K_ADDIMM, K_SUBIMM: begin
                s = '0; s.st = 4'd3; s.asrc = 1;
                s.aop = (k == K_ADDIMM) ? 4'b0010 : 4'b0110;
                plan.push_back(s);
            end
            K_MOVZ: begin
                s = '0; s.st = 4'd4; s.asrc = 1; s.sop = 3'b100; s.aop = 4'b0111;
                plan.push_back(s);
            end
            K_LDUR, K_STUR: begin
                s = '0; s.st = 4'd5; s.asrc = 1; s.sop = 3'b001; s.aop = 4'b0010;
                plan.push_back(s);
                s = '0; s.mreq = 1; s.iord = 1; s.waits = 1;
                if (k == K_LDUR) s.st = 4'd6;
                else begin s.st = 4'd7; s.mwe = 1; s.r2l = 1; end
                plan.push_back(s);
            end
            K_CBZ: begin
                s = '0; s.st = 4'd10; s.r2l = 1; s.aop = 4'b0111; s.pcsel = 1; s.cbz = 1;
                plan.push_back(s);
            end
            K_B: begin
                s = '0; s.st = 4'd11; s.pcwe = 1; s.pcsel = 1;
                plan.push_back(s);
            end
            default: begin
                s = '0; s.st = 4'd15; s.halt = 1; s.sticky = 1;
                plan.push_back(s);
            end
        endcase
        if (k inside {K_ADDREG, K_SUBREG, K_ANDREG, K_ORRREG, K_ADDIMM, K_SUBIMM, K_MOVZ}) begin
            s = '0; s.st = 4'd8; s.rfwe = 1;
            plan.push_back(s);
        end else if (k == K_LDUR) begin
            s = '0; s.st = 4'd9; s.rfwe = 1; s.m2r = 1;
            plan.push_back(s);
        end
    endtask

    // One clock: drive inputs after the edge, compare mid-cycle, then let
    // the model advance the way the next edge should.
    task automatic run_cycle();
        step_t       s;
        bit          rdy, z;
        logic [22:0] a, e;
        if (plan.size() == 0) begin
            chk("plan_nonempty", 0, 1);
            return;
        end
        s = plan[0];
        @(posedge CLK); #1;
        reset = 1'b0;
        if (s.waits && stall_left > 0 && int'(s.st) == stall_st) begin
            rdy = 0; stall_left--;
        end else if (rand_ready && consec_wait < 4) begin
            rdy = ($urandom_range(0, 2) != 0);
        end else begin
            rdy = 1;
        end
        if (s.waits && !rdy) consec_wait++; else consec_wait = 0;
        z = (zero_force < 0) ? 1'($urandom_range(0, 1)) : zero_force[0];
        mem_ready = rdy;
        zero      = z;
        opcode    = s.dec ? s.op : 11'($urandom);
        @(negedge CLK);
        a = act_vec();
        e = exp_vec(s, rdy, z);
        trace.push_back(a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t model_state=%0d actual=%h expected=%h",
                     $time, s.st, a, e);
        end
        if (!s.sticky && !(s.waits && !rdy)) void'(plan.pop_front());
        cyc_count++;
    endtask

    task automatic run_instr(input logic [10:0] op, output int ncyc);
        add_instr(op);
        trace.delete();
        cyc_count = 0;
        while (plan.size() > 0 && cyc_count < 64) run_cycle();
        if (plan.size() > 0) chk("instr_cycle_budget", cyc_count, -1);
        ncyc = cyc_count;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            reset     = 1'b1;
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            opcode    = 11'($urandom);
            @(negedge CLK);
            chk("reset_strobes_low", int'({mem_req, mem_we, ir_we, pc_we, tgt_we, rf_we}), 0);
        end
        plan.delete();
        consec_wait = 0;
    endtask

    function automatic int count_bit(input int bitpos, input int st_only);
        int          c;
        logic [22:0] v;
        c = 0;
        foreach (trace[i]) begin
            v = trace[i];
            if (v[bitpos] && (st_only < 0 || int'(v[22:19]) == st_only)) c++;
        end
        return c;
    endfunction

    function automatic logic [22:0] trace_at(input int idx);
        if (idx < trace.size()) return trace[idx];
        return '1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          exp_st[4];
        logic [22:0] v;

        do_reset(2);

        // ADDREG with zero-wait memory: 0,1,2,8 and back to FETCH.
        run_instr(11'b10001011000, n);
        chk("addreg_cycles", n, 4);
        exp_st = '{0, 1, 2, 8};
        for (int i = 0; i < 4; i++) begin
            v = trace_at(i);
            chk("addreg_state_seq", int'(v[22:19]), exp_st[i]);
        end
        v = trace_at(2);
        chk("addreg_aluop", int'(v[7:4]), 2);
        chk("addreg_rf_we_count", count_bit(11, -1), 1);
        chk("addreg_rf_we_state8", count_bit(11, 8), 1);

        // LDUR with two wait cycles in MEM_RD.
        stall_st = 6; stall_left = 2;
        run_instr(11'b11111000010, n);
        chk("ldur_cycles", n, 7);
        chk("ldur_memrd_req", count_bit(18, 6), 3);
        chk("ldur_memrd_iord", count_bit(16, 6), 3);
        v = trace_at(6);
        chk("ldur_wb_rfwe_m2r", int'({v[11], v[10], v[22:19]}), (3 << 4) | 9);
        stall_st = -1;

        // CBZ taken and not taken.
        zero_force = 1;
        run_instr(11'b10110100101, n);
        chk("cbz_taken_cycles", n, 3);
        v = trace_at(2);
        chk("cbz_taken_pcwe_pcsel", int'({v[14], v[13]}), 3);
        zero_force = 0;
        run_instr(11'b10110100011, n);
        chk("cbz_nottaken_cycles", n, 3);
        v = trace_at(2);
        chk("cbz_nottaken_pcwe_pcsel", int'({v[14], v[13]}), 1);
        zero_force = -1;

        // STUR then B.
        run_instr(11'b11111000000, n);
        chk("stur_cycles", n, 4);
        chk("stur_mem_we_count", count_bit(17, -1), 1);
        chk("stur_mem_we_state7", count_bit(17, 7), 1);
        run_instr(11'b00010100000, n);
        chk("b_cycles", n, 3);
        v = trace_at(2);
        chk("b_jump_pcwe_pcsel", int'({v[22:19], v[14], v[13]}), (11 << 2) | 3);

        // Illegal opcode halts and stays halted until reset.
        add_instr(11'b00000000000);
        trace.delete();
        for (int i = 0; i < 12; i++) run_cycle();
        chk("halt_sticky_cycles", count_bit(0, 15), 10);
        chk("halt_enables_low", count_bit(18, 15) + count_bit(14, 15) + count_bit(11, 15), 0);
        do_reset(1);
        run_instr(11'b10001011000, n);
        v = trace_at(0);
        chk("post_halt_reset_fetch", int'({v[22:19], v[0]}), 0);
        chk("post_halt_cycles", n, 4);

        // Reset in the middle of a FETCH wait.
        add_instr(11'b10001011000);
        stall_st = 0; stall_left = 5;
        run_cycle();
        run_cycle();
        do_reset(2);
        stall_left = 0; stall_st = -1;
        run_instr(11'b11010010101, n);
        chk("fetch_restart_movz_cycles", n, 4);

        // Randomized traffic with variable memory latency.
        rand_ready = 1;
        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                add_instr(gen_op(0));
                for (int i = 0; i < $urandom_range(3, 8); i++) run_cycle();
                do_reset($urandom_range(1, 2));
            end else if (r == 1) begin
                add_instr(gen_op(1));
                for (int i = 0; i < $urandom_range(1, 3); i++)
                    if (plan.size() > 0) run_cycle();
                do_reset(1);
            end else begin
                run_instr(gen_op(1), n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
